// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular fetch buffer between a two-wide fetch stage and decode. Up to two
//   entries are pushed per cycle and up to two are presented/popped per cycle.
//   Slot [1] is always the older slot on both the fetch and the output side.
//
//   Optional feature (macro FETCHQ_BYPASS_EN): when the queue is empty and
//   decode can consume, the fetch slots drive the outputs in the same cycle
//   and are consumed without ever being written into the buffer.
//
// Ports
//   clk          sole clock, rising edge
//   resetn       asynchronous active-low reset
//   fetch_valid  per-slot fetch valid ([1] older)
//   fetch_pc     per-slot PC
//   fetch_instr  per-slot instruction word
//   fetch_adel   per-slot address-error flag, carried with the entry
//   fetch_ready  room for two entries (from registered count)
//   stallD       decode/issue cannot consume this cycle
//   flushD       discard all contents (beats push and pop)
//   hitD         per-slot output valid ([1] older, 01 never occurs)
//   out_pc       per-slot output PC (zero when slot not valid)
//   out_instr    per-slot output instruction (zero when slot not valid)
//   out_adel     per-slot output address-error flag (zero when slot not valid)
//   count        occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 8     // power of two, >= 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [1:0]               fetch_valid,
    input  logic [1:0][31:0]         fetch_pc,
    input  logic [1:0][31:0]         fetch_instr,
    input  logic [1:0]               fetch_adel,
    output logic                     fetch_ready,
    input  logic                     stallD,
    input  logic                     flushD,
    output logic [1:0]               hitD,
    output logic [1:0][31:0]         out_pc,
    output logic [1:0][31:0]         out_instr,
    output logic [1:0]               out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        adel;
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_p1, tail_p1;

    entry_t        fe1, fe0;
    entry_t        rd1, rd0;
    logic [1:0]    q_hit;
    logic          bypass;
    logic          push_en, pop_en;
    logic [1:0]    n_push, n_pop;

    assign fe1 = '{adel: fetch_adel[1], instr: fetch_instr[1], pc: fetch_pc[1]};
    assign fe0 = '{adel: fetch_adel[0], instr: fetch_instr[0], pc: fetch_pc[0]};

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    // Readiness looks only at the registered count; a pop in the same cycle
    // does not free space early, which keeps this off the decode stall path.
    assign fetch_ready = (count_q <= CW'(DEPTH - 2));

    assign q_hit = {(count_q != '0), (count_q >= CW'(2))};

`ifdef FETCHQ_BYPASS_EN
    assign bypass = (count_q == '0) && !stallD && !flushD;
`else
    assign bypass = 1'b0;
`endif

    // Output mux: queue head by default, fetch slots when bypassing. Bypassed
    // slots are compacted so that a lone valid always lands in slot [1].
    always_comb begin
        hitD = q_hit;
        rd1  = q_hit[1] ? mem_q[head_q]  : '0;
        rd0  = q_hit[0] ? mem_q[head_p1] : '0;
        if (bypass) begin
            hitD = {(|fetch_valid), (&fetch_valid)};
            rd1  = fetch_valid[1] ? fe1 : (fetch_valid[0] ? fe0 : '0);
            rd0  = (&fetch_valid) ? fe0 : '0;
        end
    end

    assign out_pc    = {rd1.pc,    rd0.pc};
    assign out_instr = {rd1.instr, rd0.instr};
    assign out_adel  = {rd1.adel,  rd0.adel};
    assign count     = count_q;

    // Bypassed entries are consumed directly, so they are never written and
    // the pointers stay put.
    assign push_en = fetch_ready && !flushD && !bypass;
    assign pop_en  = !stallD && !flushD;

    always_comb begin
        n_push = push_en ? ({1'b0, fetch_valid[1]} + {1'b0, fetch_valid[0]}) : 2'd0;
        n_pop  = pop_en  ? ({1'b0, q_hit[1]} + {1'b0, q_hit[0]}) : 2'd0;

        head_d  = head_q + AW'(n_pop);
        tail_d  = tail_q + AW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(n_pop);

        if (flushD) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: stale entries are never visible because the
    // output mux zeroes any slot not covered by count.
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (fetch_valid[1]) begin
                mem_q[tail_q] <= fe1;
                if (fetch_valid[0]) begin
                    mem_q[tail_p1] <= fe0;
                end
            end else if (fetch_valid[0]) begin
                mem_q[tail_q] <= fe0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               resetn;
    logic [1:0]         fetch_valid;
    logic [1:0][31:0]   fetch_pc;
    logic [1:0][31:0]   fetch_instr;
    logic [1:0]         fetch_adel;
    logic               fetch_ready;
    logic               stallD;
    logic               flushD;
    logic [1:0]         hitD;
    logic [1:0][31:0]   out_pc;
    logic [1:0][31:0]   out_instr;
    logic [1:0]         out_adel;
    logic [3:0]         count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_adel  (fetch_adel),
        .fetch_ready (fetch_ready),
        .stallD      (stallD),
        .flushD      (flushD),
        .hitD        (hitD),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_adel    (out_adel),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        adel;
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_ctr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.instr = ~pc ^ 32'h1234_5678;
        e.adel  = pc[4];
        return e;
    endfunction

    // One clock cycle: drive fetch/control, compare outputs against the
    // scoreboard at the falling edge, then retire/enqueue at the rising edge.
    task automatic cyc(input logic [1:0] v, input logic st, input logic fl);
        ent_t e1, e0, x1, x0;
        ent_t bq[$];
        int   m, npop;
        logic rdy, byp;
        logic [1:0] eh;

        e1 = mk(pc_ctr);
        e0 = mk(v[1] ? pc_ctr + 32'd4 : pc_ctr);
        fetch_valid    = v;
        fetch_pc[1]    = e1.pc;
        fetch_instr[1] = e1.instr;
        fetch_adel[1]  = e1.adel;
        fetch_pc[0]    = e0.pc;
        fetch_instr[0] = e0.instr;
        fetch_adel[0]  = e0.adel;
        stallD         = st;
        flushD         = fl;

        @(negedge clk);
        m   = sb.size();
        rdy = ((DEPTH - m) >= 2);
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = (m == 0) && !st && !fl;
`endif
        if (byp) begin
            if (v[1]) bq.push_back(e1);
            if (v[0]) bq.push_back(e0);
        end else begin
            bq = sb;
        end
        eh = {(bq.size() >= 1), (bq.size() >= 2)};
        x1 = '0;
        x0 = '0;
        if (bq.size() >= 1) x1 = bq[0];
        if (bq.size() >= 2) x0 = bq[1];

        chk("hitD",        64'(hitD),         64'(eh));
        chk("out_pc1",     64'(out_pc[1]),    64'(x1.pc));
        chk("out_instr1",  64'(out_instr[1]), 64'(x1.instr));
        chk("out_adel1",   64'(out_adel[1]),  64'(x1.adel));
        chk("out_pc0",     64'(out_pc[0]),    64'(x0.pc));
        chk("out_instr0",  64'(out_instr[0]), 64'(x0.instr));
        chk("out_adel0",   64'(out_adel[0]),  64'(x0.adel));
        chk("count",       64'(count),        64'(m));
        chk("fetch_ready", 64'(fetch_ready),  64'(rdy));

        @(posedge clk);
        npop = int'(eh[1]) + int'(eh[0]);
        if (fl) begin
            sb.delete();
        end else if (!byp) begin
            if (!st) begin
                for (int i = 0; i < npop; i++) void'(sb.pop_front());
            end
            if (rdy) begin
                if (v[1]) sb.push_back(e1);
                if (v[0]) sb.push_back(e0);
            end
        end
        if (!fl && (byp || rdy) && (v != 2'b00)) begin
            pc_ctr = pc_ctr + ((v == 2'b11) ? 32'd8 : 32'd4);
        end
        #1;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_hitD"},        64'(hitD),        64'd0);
        chk({pfx, "_count"},       64'(count),       64'd0);
        chk({pfx, "_fetch_ready"}, 64'(fetch_ready), 64'd1);
        chk({pfx, "_out_pc"},      64'(out_pc),      64'd0);
        chk({pfx, "_out_instr"},   64'(out_instr),   64'd0);
        chk({pfx, "_out_adel"},    64'(out_adel),    64'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        fetch_valid = 2'b00;
        fetch_pc    = '0;
        fetch_instr = '0;
        fetch_adel  = 2'b00;
        stallD      = 1'b0;
        flushD      = 1'b0;
        pc_ctr      = 32'h0040_0000;

        #1;
        chk_reset_state("por");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Pair push, visible next cycle in order, then drained.
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);

        // Fill to DEPTH under stall; further pushes are ignored.
        pc_ctr = 32'h0000_1000;
        repeat (4) cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        repeat (5) cyc(2'b00, 1'b0, 1'b0);

        // Single push on slot [0] shows up compacted into slot [1].
        pc_ctr = 32'h0000_0010;
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);

        // Fill to 7 (ready drops), then stream single pushes across the wrap.
        pc_ctr = 32'h0000_2000;
        repeat (3) cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b10, 1'b1, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        repeat (12) cyc(2'b10, 1'b0, 1'b0);
        repeat (6) cyc(2'b01, 1'b1, 1'b0);
        repeat (5) cyc(2'b00, 1'b0, 1'b0);

        // Flush beats a simultaneous push and pop.
        pc_ctr = 32'h0000_3000;
        repeat (2) cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b11, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0);

        // Reset asserted mid-operation drops everything.
        repeat (2) cyc(2'b11, 1'b1, 1'b0);
        fetch_valid = 2'b00;
        #2 resetn = 1'b0;
        #1;
        chk_reset_state("midrst");
        sb.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        repeat (2) cyc(2'b00, 1'b0, 1'b0);

        // Empty-queue push with and without stall.
        pc_ctr = 32'h0000_4000;
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        repeat (2) cyc(2'b00, 1'b0, 1'b0);

        // Mixed traffic.
        pc_ctr = 32'h0000_5000;
        repeat (60) begin
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
        repeat (5) cyc(2'b00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two and at least 4.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port resetn  input  1  asynchronous, active-low reset.
REQ-004 Port fetch_valid  input  2  per-slot fetch valid; [1] is the older slot.
REQ-005 Port fetch_pc  input  2x32  per-slot PC.
REQ-006 Port fetch_instr  input  2x32  per-slot instruction word.
REQ-007 Port fetch_adel  input  2  per-slot fetch address-error flag, carried with the entry.
REQ-008 Port fetch_ready  output  1  queue can take two entries this cycle.
REQ-009 Port stallD  input  1  decode/issue cannot consume; OR of decode stall and issue-queue overflow.
REQ-010 Port flushD  input  1  discard all contents.
REQ-011 Port hitD  output  2  per-slot output valid; [1] is the older slot.
REQ-012 Port out_pc  output  2x32  output PC per slot.
REQ-013 Port out_instr  output  2x32  output instruction per slot.
REQ-014 Port out_adel  output  2  output address-error flag per slot.
REQ-015 Port count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-016 Circular buffer: head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count SHALL track occupancy from 0 to DEPTH.
REQ-017 fetch_ready SHALL be 1 iff DEPTH-count >= 2, computed from the registered count; a same-cycle pop is not credited.
REQ-018 Push SHALL occur only when fetch_ready=1 and flushD=0; fetch_valid is ignored when fetch_ready=0, and fetch holds its data.
REQ-019 Push patterns: 11 writes [1] at tail and [0] at tail+1, tail+=2; 10 writes [1] at tail, tail+=1; 01 writes [0] at tail, tail+=1; 00 no change.
REQ-020 Outputs SHALL be combinational reads of head/head+1: hitD[1]=(count>=1), hitD[0]=(count>=2); hitD=01 SHALL never occur.
REQ-021 Output data fields for a slot with hitD=0 SHALL be all-zero.
REQ-022 Pop SHALL occur when stallD=0 and flushD=0: head advances by popcount(hitD) and count decreases by the same amount.
REQ-023 Simultaneous push and pop in one cycle: count_next = count + pushed - popped; wrap-around SHALL be seamless at index DEPTH-1 to 0.
REQ-024 Flush SHALL have priority over push and pop: head=tail=0 and count=0 next cycle; entries need not be cleared.
REQ-025 Minimum latency without bypass: an entry pushed in cycle N is visible on hitD in cycle N+1.
REQ-026 Relative order of instructions SHALL be preserved end to end.

Reset
REQ-027 On resetn=0, asynchronously: head=0, tail=0, count=0, so hitD=00, all out_* zero and fetch_ready=1.
REQ-028 Assertion mid-operation SHALL drop all entries; on release the queue operates from empty with no spurious hitD.

Configuration
REQ-029 Macro FETCHQ_BYPASS_EN. When defined and count=0, stallD=0 and flushD=0, fetch slots SHALL drive hitD/out_* directly in the same cycle, compacted to [1]. They are consumed without being written, and pointers do not move.
REQ-030 When FETCHQ_BYPASS_EN is defined and count=0 but stallD=1, the entries SHALL be pushed normally. Without the macro, no bypass path exists and REQ-025 latency applies.

Verification
REQ-031 Reset, then push 11 (PC 0x00400000/0x00400004), stallD=0 -> next cycle hitD=11 with those PCs in order; following cycle count=0.
REQ-032 stallD=1, push 11 four times with DEPTH=8 -> count=8, fetch_ready=0; a fifth push is ignored and count stays 8.
REQ-033 Push 01 (PC 0x10) with queue empty -> hitD=10 and out_pc[1]=0x10.
REQ-034 Fill to count=7, pop one per cycle with 1-entry pushes across index 7 to 0 -> PC sequence stays contiguous through the wrap.
REQ-035 Same cycle: flushD=1, push 11, stallD=0 -> next cycle count=0 and hitD=00.
REQ-036 With FETCHQ_BYPASS_EN, empty queue, push 11, stallD=0 -> hitD=11 in the same cycle and count stays 0; repeat with stallD=1 -> count=2.
